// File: rtl/mem_responder_rv_if.sv
// Memory-side bus between the RV32 core and its responder, plus the console TX stream.
// The core drives the read/write address channels; the responder returns read data, console bytes and the error flag.
interface mem_responder_rv_if;
   logic [31:0] iwReadAddr;
   logic [31:0] owReadData;
   logic [31:0] iwWriteAddr;
   logic [31:0] iwWriteData;
   logic [3:0]  iwWstrb;
   logic        owConsoleValid;
   logic [7:0]  owConsoleData;
   logic        iwConsoleReady;
   logic        owBusError;

   modport master (
      output iwReadAddr, iwWriteAddr, iwWriteData, iwWstrb, iwConsoleReady,
      input  owReadData, owConsoleValid, owConsoleData, owBusError
   );

   modport slave (
      input  iwReadAddr, iwWriteAddr, iwWriteData, iwWstrb, iwConsoleReady,
      output owReadData, owConsoleValid, owConsoleData, owBusError
   );
endinterface

// File: rtl/mem_responder_rv.sv
// Word RAM plus MMIO (console TX FIFO, status, cycle counter); reads take pReadLatency cycles (read-first).
// No stall on the core side: console drains on valid/ready, and a push into a full, non-draining FIFO is dropped.
module mem_responder_rv #(
   parameter logic        pReadLatency = 1'b1,
   parameter int unsigned pDepthWords  = 4096,
   parameter logic [31:0] pMmioBase    = 32'h1000_0000,
   parameter string       pInitFile    = ""
) (
   input logic               iwClk,
   input logic               iwnRst,
   mem_responder_rv_if.slave bus
);
   localparam int          AW         = $clog2(pDepthWords);
   localparam logic [29:0] MMIO_WBASE = pMmioBase[31:2];

   logic [31:0] mem_q [pDepthWords];

   function automatic logic in_ram(input logic [29:0] w);
      return {2'b00, w} < pDepthWords;
   endfunction

   function automatic logic in_mmio(input logic [29:0] w);
      return (w >= MMIO_WBASE) && (w < MMIO_WBASE + 30'd4);
   endfunction

   logic [7:0]  fifo_q [4];
   logic [7:0]  fifo_d [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic [31:0] cyc_q, cyc_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] raddr_q, raddr_d;
   logic        first_q, first_d;
   logic        berr_q, berr_d;

   logic [1:0]  woff, moff, roff;
   logic [3:0]  wlanes;
   logic [31:0] wdat, rd_val;
   logic [29:0] wword, rword;
   logic        w_ram, w_mmio, w_oor, wr_tx, wr_stat, wr_cyc;
   logic        r_ram, r_mmio, pop, push_ok;

   always_comb begin
      woff    = bus.iwWriteAddr[1:0];
      wlanes  = bus.iwWstrb << woff;
      wdat    = bus.iwWriteData << {woff, 3'b000};
      wword   = bus.iwWriteAddr[31:2];
      moff    = 2'(wword - MMIO_WBASE);
      w_ram   = (wlanes != 4'd0) && in_ram(wword);
      w_mmio  = (wlanes != 4'd0) && !in_ram(wword) && in_mmio(wword);
      w_oor   = (wlanes != 4'd0) && !in_ram(wword) && !in_mmio(wword);
      wr_tx   = w_mmio && (moff == 2'd0) && wlanes[0];
      wr_stat = w_mmio && (moff == 2'd1);
      wr_cyc  = w_mmio && (moff == 2'd2);

      pop     = (cnt_q != 3'd0) && bus.iwConsoleReady;
      // A full FIFO still takes a byte when its head leaves in the same cycle.
      push_ok = wr_tx && ((cnt_q != 3'd4) || pop);

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         fifo_d[wr_ptr_q] = wdat[7:0];
         wr_ptr_d         = wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase

      ovf_d = ovf_q;
      if (wr_stat) ovf_d = 1'b0;
      if (wr_tx && !push_ok) ovf_d = 1'b1;

      cyc_d = wr_cyc ? 32'd0 : cyc_q + 32'd1;

      rword  = bus.iwReadAddr[31:2];
      roff   = 2'(rword - MMIO_WBASE);
      r_ram  = in_ram(rword);
      r_mmio = !r_ram && in_mmio(rword);
      rd_val = 32'd0;
      if (r_ram) begin
         rd_val = mem_q[rword[AW-1:0]];
      end else if (r_mmio) begin
         case (roff)
            2'd1:    rd_val = {25'd0, cnt_q, 1'b0, ovf_q, (cnt_q == 3'd0), (cnt_q == 3'd4)};
            2'd2:    rd_val = cyc_q;
            default: rd_val = 32'd0;
         endcase
      end
      rdata_d = rd_val;

      // An out-of-range read address is flagged once, not on every cycle it is held.
      raddr_d = bus.iwReadAddr;
      first_d = 1'b0;
      berr_d  = berr_q | w_oor
              | (!r_ram && !r_mmio && (first_q || (bus.iwReadAddr != raddr_q)));
   end

   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         fifo_q   <= '{default: '0};
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         cnt_q    <= 3'd0;
         ovf_q    <= 1'b0;
         cyc_q    <= 32'd0;
         rdata_q  <= 32'd0;
         raddr_q  <= 32'd0;
         first_q  <= 1'b1;
         berr_q   <= 1'b0;
      end else begin
         fifo_q   <= fifo_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         cyc_q    <= cyc_d;
         rdata_q  <= rdata_d;
         raddr_q  <= raddr_d;
         first_q  <= first_d;
         berr_q   <= berr_d;
      end
   end

   // RAM is not reset, but a write landing while reset is held is discarded.
   always_ff @(posedge iwClk) begin
      if (iwnRst && w_ram) begin
         for (int b = 0; b < 4; b++) begin
            if (wlanes[b]) mem_q[wword[AW-1:0]][8*b +: 8] <= wdat[8*b +: 8];
         end
      end
   end

   assign bus.owReadData     = pReadLatency ? rdata_q : rd_val;
   assign bus.owConsoleValid = (cnt_q != 3'd0);
   assign bus.owConsoleData  = (cnt_q != 3'd0) ? fifo_q[rd_ptr_q] : 8'd0;
   assign bus.owBusError     = berr_q;
endmodule

// File: tb/tb_mem_responder_rv.sv
// Directed bench for mem_responder_rv: read and console expectations go through scoreboard queues
// drained by a negedge monitor; level checks of flags are made directly.
module tb_mem_responder_rv;
   localparam logic [31:0] TX   = 32'h1000_0000;
   localparam logic [31:0] STAT = 32'h1000_0004;
   localparam logic [31:0] CYC  = 32'h1000_0008;
   localparam logic [31:0] RSV  = 32'h1000_000C;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_responder_rv_if bus();

   mem_responder_rv #(
      .pReadLatency (1'b1),
      .pDepthWords  (4096),
      .pMmioBase    (32'h1000_0000),
      .pInitFile    ("")
   ) dut (
      .iwClk  (clk),
      .iwnRst (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] rd_q[$];
   string       rd_name_q[$];
   logic [7:0]  con_q[$];
   logic        rd_chk  = 1'b0;
   logic        rd_pend = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: read data one edge after a read was issued, console bytes on every handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rd_pend) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL read_scoreboard_empty: got %h expected none", bus.owReadData);
            end else begin
               chk(rd_name_q.pop_front(), bus.owReadData, rd_q.pop_front());
            end
         end
         rd_pend = rd_chk;
         if (rst_n && bus.owConsoleValid && bus.iwConsoleReady) begin
            if (con_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL console_unexpected: got %h expected no byte", bus.owConsoleData);
            end else begin
               chk("console_byte", {24'd0, bus.owConsoleData}, {24'd0, con_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic acc(input bit do_rd, input logic [31:0] ra, input logic [31:0] rexp,
                      input string nm, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws);
      if (do_rd) begin
         bus.iwReadAddr = ra;
         rd_q.push_back(rexp);
         rd_name_q.push_back(nm);
         rd_chk = 1'b1;
      end
      bus.iwWriteAddr = wa;
      bus.iwWriteData = wd;
      bus.iwWstrb     = ws;
      step();
      rd_chk         = 1'b0;
      bus.iwReadAddr = 32'd0;
      bus.iwWstrb    = 4'd0;
   endtask

   task automatic rd(input logic [31:0] ra, input logic [31:0] rexp, input string nm);
      acc(1'b1, ra, rexp, nm, 32'd0, 32'd0, 4'd0);
   endtask

   task automatic wr(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
      acc(1'b0, 32'd0, 32'd0, "", wa, wd, ws);
   endtask

   initial begin
      logic [7:0] msg [5];
      msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
      bus.iwReadAddr     = 32'd0;
      bus.iwWriteAddr    = 32'd0;
      bus.iwWriteData    = 32'd0;
      bus.iwWstrb        = 4'd0;
      bus.iwConsoleReady = 1'b0;

      #2;
      chk("reset_read_data", bus.owReadData, 32'd0);
      chk("reset_console", {23'd0, bus.owConsoleValid, bus.owConsoleData}, 32'd0);
      chk("reset_bus_error", {31'd0, bus.owBusError}, 32'd0);
      repeat (3) step();
      rst_n = 1'b1;

      // Cycle counter: 10 edges after release, then clear and count 3.
      repeat (10) step();
      rd(CYC, 32'd10, "cycle_after_10");
      wr(CYC, 32'd0, 4'b1111);
      repeat (3) step();
      rd(CYC, 32'd3, "cycle_after_clear");
      rd(STAT, 32'h02, "status_empty");
      rd(TX, 32'd0, "tx_reads_zero");
      rd(RSV, 32'd0, "reserved_reads_zero");
      force dut.cyc_q = 32'hFFFF_FFFF;
      #1;
      release dut.cyc_q;
      rd(CYC, 32'hFFFF_FFFF, "cycle_max");
      rd(CYC, 32'd0, "cycle_wrap");

      // RAM: read-first, word, sub-word and misaligned stores.
      wr(32'h100, 32'h0102_0304, 4'b1111);
      acc(1'b1, 32'h100, 32'h0102_0304, "read_first", 32'h100, 32'hDEAD_BEEF, 4'b1111);
      rd(32'h100, 32'hDEAD_BEEF, "word_store_read");
      wr(32'h200, 32'h1122_3344, 4'b1111);
      wr(32'h203, 32'h0000_00AB, 4'b0001);
      wr(32'h200, 32'h0000_CDEF, 4'b0011);
      rd(32'h200, 32'hAB22_CDEF, "subword_merge");
      wr(32'h300, 32'd0, 4'b1111);
      wr(32'h303, 32'h0000_BEEF, 4'b0011);
      rd(32'h300, 32'hEF00_0000, "misaligned_half_truncated");
      wr(32'h302, 32'h0000_1234, 4'b0011);
      rd(32'h300, 32'h1234_0000, "half_at_offset2");
      wr(32'h3FFC, 32'h5A5A_5A5A, 4'b1111);
      rd(32'h3FFC, 32'h5A5A_5A5A, "ram_last_word");

      // Console FIFO: fill, overflow, push+pop while full, drain.
      for (int i = 0; i < 5; i++) begin
         if (i < 4) con_q.push_back(msg[i]);
         wr(TX, {24'd0, msg[i]}, 4'b0001);
      end
      rd(STAT, 32'h45, "status_full_overflow");
      chk("console_head", {23'd0, bus.owConsoleValid, bus.owConsoleData}, {23'd0, 1'b1, 8'h41});
      wr(STAT, 32'd0, 4'b0001);
      rd(STAT, 32'h41, "status_full_ovf_cleared");
      bus.iwConsoleReady = 1'b1;
      con_q.push_back(8'h46);
      wr(TX, 32'h46, 4'b0001);
      bus.iwConsoleReady = 1'b0;
      rd(STAT, 32'h41, "status_full_after_pushpop");
      bus.iwConsoleReady = 1'b1;
      repeat (5) step();
      bus.iwConsoleReady = 1'b0;
      chk("console_drained", {23'd0, bus.owConsoleValid, bus.owConsoleData}, 32'd0);
      rd(STAT, 32'h02, "status_drained");
      chk("console_queue_empty", con_q.size(), 32'd0);
      wr(TX + 32'd1, 32'h0000_0055, 4'b0001);
      chk("tx_without_lane0", {31'd0, bus.owConsoleValid}, 32'd0);

      // Bus error: out-of-range read, then write that must not alias into RAM.
      wr(32'h0, 32'hCAFE_F00D, 4'b1111);
      chk("berr_clear_before", {31'd0, bus.owBusError}, 32'd0);
      rd(32'h2000_0000, 32'd0, "oor_read_zero");
      chk("berr_after_read", {31'd0, bus.owBusError}, 32'd1);
      wr(32'h0800_0000, 32'h1234_5678, 4'b1111);
      rd(32'h0, 32'hCAFE_F00D, "ram_unchanged_by_oor");
      chk("berr_sticky", {31'd0, bus.owBusError}, 32'd1);

      // Async reset with two bytes queued and the counter at 50.
      wr(TX, 32'h78, 4'b0001);
      wr(TX, 32'h79, 4'b0001);
      wr(CYC, 32'd0, 4'b1111);
      repeat (49) step();
      rd(CYC, 32'd49, "cycle_49");
      chk("console_before_reset", {23'd0, bus.owConsoleValid, bus.owConsoleData}, {23'd0, 1'b1, 8'h78});
      #6;
      rst_n = 1'b0;
      #1;
      chk("async_read_data", bus.owReadData, 32'd0);
      chk("async_console", {23'd0, bus.owConsoleValid, bus.owConsoleData}, 32'd0);
      chk("async_bus_error", {31'd0, bus.owBusError}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      rd(CYC, 32'd0, "cycle_after_reset");
      rd(32'h100, 32'hDEAD_BEEF, "ram_survives_reset");
      rd(STAT, 32'h02, "status_after_reset");
      wr(32'h0800_0000, 32'h1, 4'b1111);
      chk("berr_after_write", {31'd0, bus.owBusError}, 32'd1);

      step();
      step();
      chk("read_queue_empty", rd_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
